// File: rtl/seg_scan_display_n.sv
// Multiplexed seven-segment scanner for N_FIELDS two-digit fields.
// Each 6-bit field is converted to decimal by repeated subtraction of ten.
// The converted digits are first written into a pending buffer. They are
// copied to the display buffer in a single cycle, so the display never shows
// a partly updated value.
// Handshake: load is a one-cycle request. It is accepted only while the
// registered state is IDLE. busy is high from the cycle after the capture
// until the cycle after the commit, and any load seen while busy is dropped.
module seg_scan_display_n #(
  parameter int N_FIELDS   = 4,
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_HALF = 125
) (
  input  logic                    clk_500Hz,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [6*N_FIELDS-1:0]   field_bus,
  input  logic [N_FIELDS-1:0]     blink_mask,
  input  logic [2*N_FIELDS-1:0]   dp_mask,
  output logic                    busy,
  output logic [2*N_FIELDS-1:0]   seg_en,
  output logic [7:0]              seg_out
);
  localparam int N_DIGITS = 2 * N_FIELDS;
  localparam int FW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
  localparam int DW = $clog2(N_DIGITS);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic [6*N_FIELDS-1:0]   shadow;
  logic [FW-1:0]           fidx;
  logic [5:0]              rem;
  logic [3:0]              tens;
  logic [4*N_DIGITS-1:0]   pending;
  logic [4*N_DIGITS-1:0]   disp;
  logic [SW-1:0]           scan_cnt;
  logic [DW-1:0]           dig_idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic                    last_field;
  logic                    rem_ge10;
  logic [5:0]              next_field;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_blink;
  logic [7:0]              seg_pat;

  assign last_field = (fidx == FW'(N_FIELDS - 1));
  assign rem_ge10   = (rem >= 6'd10);
  assign busy       = (state_q != IDLE);

  // Select the shadow field that follows the one currently being converted.
  always_comb begin
    next_field = '0;
    for (int k = 0; k < N_FIELDS; k++) begin
      if (FW'(k) == fidx + FW'(1)) next_field = shadow[6*k +: 6];
    end
  end

  // State register for the conversion FSM.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic for the conversion FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = CONV;
      CONV:    if (!rem_ge10 && last_field) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Conversion datapath: capture, subtract-ten steps, pending writes, commit.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      fidx    <= '0;
      rem     <= '0;
      tens    <= '0;
      pending <= '0;
      disp    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            shadow <= field_bus;
            fidx   <= '0;
            rem    <= field_bus[5:0];
            tens   <= '0;
          end
        end
        CONV: begin
          if (rem_ge10) begin
            rem  <= rem - 6'd10;
            tens <= tens + 4'd1;
          end else begin
            for (int k = 0; k < N_FIELDS; k++) begin
              if (FW'(k) == fidx) begin
                pending[8*k +: 4]     <= rem[3:0];
                pending[8*k + 4 +: 4] <= tens;
              end
            end
            if (!last_field) begin
              fidx <= fidx + FW'(1);
              rem  <= next_field;
              tens <= '0;
            end
          end
        end
        COMMIT:  disp <= pending;
        default: ;
      endcase
    end
  end

  // Scan divider and digit index; the scan runs regardless of en and busy.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == DW'(N_DIGITS - 1)) ? '0 : dig_idx + DW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Blink half-period counter and phase toggle.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Fetch the digit, decimal point and blink enable for the current index.
  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (DW'(d) == dig_idx) begin
        cur_digit = disp[4*d +: 4];
        cur_dp    = dp_mask[d];
        cur_blink = blink_mask[d/2];
      end
    end
  end

  // Seven-segment decode, {a,b,c,d,e,f,g,dp}, active-high.
  always_comb begin
    seg_pat = 8'h00;
    unique case (cur_digit)
      4'd0:    seg_pat = 8'hFC;
      4'd1:    seg_pat = 8'h60;
      4'd2:    seg_pat = 8'hDA;
      4'd3:    seg_pat = 8'hF2;
      4'd4:    seg_pat = 8'h66;
      4'd5:    seg_pat = 8'hB6;
      4'd6:    seg_pat = 8'hBE;
      4'd7:    seg_pat = 8'hE0;
      4'd8:    seg_pat = 8'hFE;
      4'd9:    seg_pat = 8'hF6;
      default: seg_pat = 8'h00;
    endcase
  end

  // Output drive: one-hot digit enable and blank-or-pattern segment data.
  always_comb begin
    seg_en  = en ? (N_DIGITS'(1) << dig_idx) : '0;
    seg_out = (cur_blink && blink_phase) ? 8'h00 : {seg_pat[7:1], cur_dp};
  end

endmodule

// File: tb/tb_seg_scan_display_n.sv
// Bench for seg_scan_display_n with 4 fields, scan divider 3 and blink half 4.
// The reference model derives the index and blink phase from a count of clock
// cycles since reset. It derives the digits by taking each value mod 10 and
// div 10.
module tb_seg_scan_display_n;
  localparam int NF = 4;
  localparam int ND = 8;
  localparam int SD = 3;
  localparam int BH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [23:0]   field_bus;
  logic [3:0]    blink_mask;
  logic [7:0]    dp_mask;
  logic          busy;
  logic [7:0]    seg_en;
  logic [7:0]    seg_out;

  int            cyc;
  int            n_checks;
  int            n_pass;
  int            n_fail;
  int            md[ND];
  logic [7:0]    pat[10];
  logic [3:0]    exp_q[$];

  // Clock generation.
  always #5 clk = ~clk;

  seg_scan_display_n #(.N_FIELDS(NF), .SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
    .clk_500Hz  (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .field_bus  (field_bus),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .busy       (busy),
    .seg_en     (seg_en),
    .seg_out    (seg_out)
  );

  // Watchdog: guarantees termination even if the run wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock; cycles count only when reset was released at the edge.
  task automatic step();
    logic r;
    @(posedge clk);
    r = rst_n;
    #1;
    if (r === 1'b1) cyc++;
  endtask

  task automatic check_display();
    int idx;
    int ph;
    logic [7:0] e_en;
    logic [7:0] e_seg;
    idx  = (cyc / SD) % ND;
    ph   = (cyc / BH) % 2;
    e_en = en ? 8'(1 << idx) : 8'h00;
    if (blink_mask[idx/2] && ph == 1) e_seg = 8'h00;
    else e_seg = {pat[md[idx]][7:1], dp_mask[idx]};
    chk("seg_en", seg_en, e_en);
    chk("seg_out", seg_out, e_seg);
  endtask

  task automatic clear_model();
    cyc = 0;
    for (int d = 0; d < ND; d++) md[d] = 0;
    exp_q.delete();
  endtask

  task automatic do_load(input logic [23:0] fb, input bit reload);
    int lat;
    int v;
    lat = 1;
    for (int k = 0; k < NF; k++) begin
      v = int'(fb[6*k +: 6]);
      lat += v / 10 + 1;
      exp_q.push_back(4'(v % 10));
      exp_q.push_back(4'(v / 10));
    end
    field_bus = fb;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("busy_start", {7'b0, busy}, 8'h01);
    check_display();
    for (int k = 1; k <= lat; k++) begin
      if (reload && k == 4) begin
        load = 1'b1;
        field_bus = 24'($urandom);
      end
      step();
      load = 1'b0;
      if (k == lat) begin
        for (int d = 0; d < ND; d++) md[d] = int'(exp_q.pop_front());
      end
      chk("busy", {7'b0, busy}, (k < lat) ? 8'h01 : 8'h00);
      check_display();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_display();
    end
  endtask

  initial begin
    pat[0] = 8'hFC; pat[1] = 8'h60; pat[2] = 8'hDA; pat[3] = 8'hF2;
    pat[4] = 8'h66; pat[5] = 8'hB6; pat[6] = 8'hBE; pat[7] = 8'hE0;
    pat[8] = 8'hFE; pat[9] = 8'hF6;
    n_checks = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0; en = 1'b1; load = 1'b0; field_bus = '0;
    blink_mask = '0; dp_mask = '0;
    clear_model();
    #1;
    chk("reset_busy", {7'b0, busy}, 8'h00);
    chk("reset_seg_en", seg_en, 8'h01);
    chk("reset_seg_out", seg_out, 8'hFC);
    step();
    step();
    rst_n = 1'b1;
    idle(4);

    // All-zero load: busy for exactly 5 cycles, display stays zero.
    do_load(24'd0, 1'b0);
    idle(5);

    // Mixed fields including 63 with a dropped reload pulse during busy.
    do_load({6'd63, 6'd0, 6'd7, 6'd59}, 1'b1);
    idle(30);

    // Enable off mid-scan, then back on at the correct position.
    en = 1'b0;
    idle(10);
    en = 1'b1;
    idle(8);

    // Blink field 1 with its ones-digit decimal point lit.
    blink_mask = 4'b0010;
    dp_mask = 8'h04;
    idle(48);
    blink_mask = '0;
    dp_mask = '0;

    // Reset during conversion of a pending load.
    field_bus = {18'd0, 6'd42};
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("rst_mid_busy", {7'b0, busy}, 8'h00);
    check_display();
    step();
    check_display();
    rst_n = 1'b1;
    idle(3);
    do_load({6'd12, 6'd33, 6'd5, 6'd42}, 1'b0);
    idle(10);

    // Randomized loads, masks and enable.
    for (int r = 0; r < 6; r++) begin
      dp_mask = 8'($urandom);
      blink_mask = 4'($urandom_range(0, 15));
      en = 1'($urandom_range(0, 1));
      do_load({6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
               6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))}, 1'($urandom_range(0, 1)));
      en = 1'b1;
      idle(int'($urandom_range(8, 30)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
